// File: rtl/arith_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_operand_stage_pkg
//  Description : Shared constants for the add/sub operand issue stage:
//                data width, register count, register address width and
//                the add/subtract control encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package arith_operand_stage_pkg;

  localparam int SIZE = 32;  // operand/data width in bits
  localparam int NREG = 32;  // number of architectural registers
  localparam int AW   = 5;   // register address width, log2(NREG)

  localparam logic CTRL_ADD = 1'b0;
  localparam logic CTRL_SUB = 1'b1;

  // True when a write port update targets the given read address.
  // Register 0 is never written, so it can never be a forwarding source.
  function automatic logic wr_hit(input logic          wen,
                                  input logic [AW-1:0] wa,
                                  input logic [AW-1:0] ra);
    return wen && (wa != '0) && (wa == ra);
  endfunction

endpackage : arith_operand_stage_pkg
`default_nettype wire

// File: rtl/arith_operand_stage_rf_32x32.sv
`default_nettype none
// ============================================================================
//  Module      : rf_32x32
//  Description : 32 x 32-bit register file with two combinational read
//                ports and one synchronous write port. Synchronous reset
//                clears every entry; register 0 always reads zero and
//                ignores writes.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_32x32
  import arith_operand_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra0,
  output logic [SIZE-1:0] rd0,
  input  logic [AW-1:0]   ra1,
  output logic [SIZE-1:0] rd1,
  input  logic            wen,
  input  logic [AW-1:0]   wa,
  input  logic [SIZE-1:0] wd
);

  logic [SIZE-1:0] r_mem [NREG];

  // Storage update: reset clears everything, otherwise one write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wen && (wa != '0)) begin
      r_mem[wa] <= wd;
    end
  end

  // Read ports: register 0 is forced to zero regardless of storage contents.
  always_comb begin
    rd0 = (ra0 == '0) ? '0 : r_mem[ra0];
    rd1 = (ra1 == '0) ? '0 : r_mem[ra1];
  end

endmodule : rf_32x32
`default_nettype wire

// File: rtl/arith_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : arith_operand_stage
//  Description : Issue stage for the 32-bit add/sub unit. Reads two source
//                registers per accepted request and holds a, b and ctrl in a
//                one-deep valid/ready output register so the consumer can
//                stall. Writeback updates the register file every cycle,
//                independent of the handshake.
//  Config      : RF_BYPASS_EN - when defined, a write landing in the same
//                cycle as an accept is forwarded into the captured operand;
//                when undefined the old register value is captured.
//  Revision    : 1.0  initial release
// ============================================================================
module arith_operand_stage
  import arith_operand_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic            ctrl_in,
  input  logic            wen,
  input  logic [AW-1:0]   wa,
  input  logic [SIZE-1:0] wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] a,
  output logic [SIZE-1:0] b,
  output logic            ctrl
);

  logic [SIZE-1:0] w_rf_a;
  logic [SIZE-1:0] w_rf_b;
  logic [SIZE-1:0] w_op_a;
  logic [SIZE-1:0] w_op_b;
  logic            w_accept;

  logic            r_out_valid;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic            r_ctrl;

  rf_32x32 u_rf (
    .clk (clk),
    .rst (rst),
    .ra0 (rs),
    .rd0 (w_rf_a),
    .ra1 (rt),
    .rd1 (w_rf_b),
    .wen (wen),
    .wa  (wa),
    .wd  (wd)
  );

  // Operand select: forward same-cycle write data, or use the stored value.
  always_comb begin
`ifdef RF_BYPASS_EN
    w_op_a = wr_hit(wen, wa, rs) ? wd : w_rf_a;
    w_op_b = wr_hit(wen, wa, rt) ? wd : w_rf_b;
`else
    w_op_a = w_rf_a;
    w_op_b = w_rf_b;
`endif
  end

  // Handshake: the output register frees up when empty or being drained.
  always_comb begin
    in_ready = !r_out_valid || out_ready;
    w_accept = in_valid && in_ready;
  end

  // Output register: capture on accept, empty on transfer, hold on stall.
  // Operands are snapshots, so later writes never disturb a held request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_ctrl      <= CTRL_ADD;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_a         <= w_op_a;
      r_b         <= w_op_b;
      r_ctrl      <= ctrl_in;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign ctrl      = r_ctrl;

endmodule : arith_operand_stage
`default_nettype wire

// File: tb/tb_arith_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_operand_stage
//  Description : Directed self-checking bench for arith_operand_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arith_operand_stage;
  import arith_operand_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   rs;
  logic [AW-1:0]   rt;
  logic            ctrl_in;
  logic            wen;
  logic [AW-1:0]   wa;
  logic [SIZE-1:0] wd;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arith_operand_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .rt        (rt),
    .ctrl_in   (ctrl_in),
    .wen       (wen),
    .wa        (wa),
    .wd        (wd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [SIZE-1:0] data);
    wen = 1'b1; wa = addr; wd = data;
    tick();
    wen = 1'b0;
  endtask

  task automatic req(input logic [AW-1:0] s, input logic [AW-1:0] t, input logic c);
    in_valid = 1'b1; rs = s; rt = t; ctrl_in = c;
  endtask

  logic [SIZE-1:0] exp_same;

  initial begin
    rst = 1'b1; in_valid = 1'b0; rs = '0; rt = '0; ctrl_in = 1'b0;
    wen = 1'b0; wa = '0; wd = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_ctrl", {31'd0, ctrl}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: basic read after writes, 1-cycle latency
    wr(5'd3, 32'd7);
    wr(5'd4, 32'd5);
    req(5'd3, 5'd4, CTRL_SUB);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_a", a, 32'd7);
    chk("t1_b", b, 32'd5);
    chk("t1_ctrl", {31'd0, ctrl}, 32'd1);
    tick();
    chk("t1_drain", {31'd0, out_valid}, 32'd0);

    // 2: writes to R0 ignored, R0 reads zero
    wr(5'd0, 32'hFFFF_FFFF);
    req(5'd0, 5'd0, CTRL_ADD);
    tick();
    in_valid = 1'b0;
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_a", a, 32'd0);
    chk("t2_b", b, 32'd0);
    chk("t2_ctrl", {31'd0, ctrl}, 32'd0);
    tick();

    // 3: stall holds captured operands despite a later write
    out_ready = 1'b0;
    req(5'd3, 5'd4, CTRL_SUB);
    tick();
    req(5'd4, 5'd3, CTRL_ADD);   // must not be accepted while stalled
    for (int i = 0; i < 3; i++) begin
      wen = (i == 0); wa = 5'd3; wd = 32'd9;
      #1;
      chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_a", a, 32'd7);
      chk("t3_b", b, 32'd5);
      chk("t3_ctrl", {31'd0, ctrl}, 32'd1);
    end
    wen = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t3_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t3_one_xfer", {31'd0, out_valid}, 32'd0);
    // confirm the stall-time write landed
    req(5'd3, 5'd0, CTRL_ADD);
    tick();
    in_valid = 1'b0;
    chk("t3_r3_new", a, 32'd9);
    tick();

    // 4: same-cycle write and accept
    wr(5'd3, 32'd7);
    wen = 1'b1; wa = 5'd3; wd = 32'd11;
    req(5'd3, 5'd4, CTRL_ADD);
    tick();
    wen = 1'b0; in_valid = 1'b0;
`ifdef RF_BYPASS_EN
    exp_same = 32'd11;
`else
    exp_same = 32'd7;
`endif
    chk("t4_a_same_cycle", a, exp_same);
    chk("t4_b", b, 32'd5);
    tick();
    req(5'd0, 5'd3, CTRL_ADD);
    tick();
    in_valid = 1'b0;
    chk("t4_r3_written", b, 32'd11);
    tick();

    // 5: back-to-back, no bubbles
    wr(5'd3, 32'd7);
    req(5'd3, 5'd4, CTRL_ADD);
    tick();
    chk("t5_v0", {31'd0, out_valid}, 32'd1);
    chk("t5_a0", a, 32'd7);
    chk("t5_b0", b, 32'd5);
    req(5'd4, 5'd3, CTRL_SUB);
    tick();
    chk("t5_v1", {31'd0, out_valid}, 32'd1);
    chk("t5_a1", a, 32'd5);
    chk("t5_b1", b, 32'd7);
    chk("t5_c1", {31'd0, ctrl}, 32'd1);
    req(5'd0, 5'd3, CTRL_ADD);
    tick();
    in_valid = 1'b0;
    chk("t5_v2", {31'd0, out_valid}, 32'd1);
    chk("t5_a2", a, 32'd0);
    chk("t5_b2", b, 32'd7);
    tick();
    chk("t5_end", {31'd0, out_valid}, 32'd0);

    // 6: reset during a stall, write on the reset cycle discarded
    out_ready = 1'b0;
    req(5'd3, 5'd4, CTRL_SUB);
    tick();
    in_valid = 1'b0;
    chk("t6_held", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; wen = 1'b1; wa = 5'd5; wd = 32'h1234_5678;
    tick();
    rst = 1'b0; wen = 1'b0;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_a", a, 32'd0);
    chk("t6_b", b, 32'd0);
    chk("t6_ctrl", {31'd0, ctrl}, 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i < NREG; i++) begin
      req(AW'(i), AW'(NREG - i), CTRL_ADD);
      tick();
      chk("t6_rf_a", a, 32'd0);
      chk("t6_rf_b", b, 32'd0);
    end
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_arith_operand_stage
`default_nettype wire
